// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared pipeline definitions for the elastic ID/EX-style stage register:
// occupancy state encoding, control sub-field widths and the bubble control word.
package pipe_stage_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  localparam int unsigned WB_W       = 2;
  localparam int unsigned M_W        = 3;
  localparam int unsigned EX_W       = 4;
  localparam int unsigned CTRL_W_DEF = WB_W + M_W + EX_W;

  localparam logic [CTRL_W_DEF-1:0] BUBBLE_CTRL_DEF = '0;

endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline register: main + skid entry with registered in_ready,
// synchronous flush to bubbles and a saturating bubble counter.
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int unsigned          CTRL_W      = CTRL_W_DEF,
  parameter int unsigned          DATA_W      = 148,
  parameter logic [CTRL_W-1:0]    BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEF),
  parameter int unsigned          CNT_W       = 16
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  occ_state_e        state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              push;
  logic              pop;

  // Both handshake flags come from the state register only, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = BUBBLE_CTRL;
      main_data_d = '0;
      skid_ctrl_d = BUBBLE_CTRL;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d     = ST_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (push) begin
            state_d     = ST_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (pop) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = BUBBLE_CTRL;
            main_data_d = '0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d     = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = BUBBLE_CTRL;
            skid_data_d = '0;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = BUBBLE_CTRL;
          main_data_d = '0;
          skid_ctrl_d = BUBBLE_CTRL;
          skid_data_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= BUBBLE_CTRL;
      main_data_q <= '0;
      skid_ctrl_q <= BUBBLE_CTRL;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;

  sat_counter #(
    .W(CNT_W)
  ) u_bubble_cnt (
    .clk(clk),
    .clr(startin),
    .inc(out_ready & ~out_valid),
    .cnt(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_skid_reg;

  localparam int unsigned CTRL_W = 9;
  localparam int unsigned DATA_W = 148;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SAT    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              startin = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .BUBBLE_CTRL(9'h000),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .startin(startin),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_ctrl(in_ctrl),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl(out_ctrl),
    .out_data(out_data),
    .occupancy(occupancy),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries plus a saturating count.
  logic [CTRL_W+DATA_W-1:0] mq[$];
  int unsigned              m_cnt  = 0;
  bit                       chk_en = 1'b0;

  always @(posedge clk) begin
    if (startin) begin
      mq.delete();
      m_cnt  = 0;
      chk_en = 1'b1;
    end else begin
      bit has, rdy;
      has = (mq.size() > 0);
      rdy = (mq.size() < 2);
      if (out_ready && !has && m_cnt < SAT) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (has && out_ready) void'(mq.pop_front());
        if (in_valid && rdy) mq.push_back({in_ctrl, in_data});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [CTRL_W-1:0] e_ctrl;
      logic [DATA_W-1:0] e_data;
      e_ctrl = '0;
      e_data = '0;
      if (mq.size() > 0) begin
        e_ctrl = mq[0][CTRL_W+DATA_W-1:DATA_W];
        e_data = mq[0][DATA_W-1:0];
      end
      chk("m_out_valid", 160'(out_valid), 160'(mq.size() > 0));
      chk("m_in_ready",  160'(in_ready),  160'(mq.size() < 2));
      chk("m_occupancy", 160'(occupancy), 160'(mq.size()));
      chk("m_out_ctrl",  160'(out_ctrl),  160'(e_ctrl));
      chk("m_out_data",  160'(out_data),  160'(e_data));
      chk("m_bubble_cnt", 160'(bubble_cnt), 160'(m_cnt));
    end
  end

  function automatic logic [DATA_W-1:0] rnd_data();
    return {20'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_ctrl(input logic [CTRL_W-1:0] c);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = rnd_data();
  endtask

  initial begin
    // Reset held two cycles while an entry is offered.
    startin  = 1'b1;
    in_valid = 1'b1;
    in_ctrl  = 9'h1FF;
    in_data  = rnd_data();
    cyc();
    cyc();
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_out_ctrl",  160'(out_ctrl),  160'(0));
    chk("rst_out_data",  160'(out_data),  160'(0));
    chk("rst_occupancy", 160'(occupancy), 160'(0));
    chk("rst_in_ready",  160'(in_ready),  160'(1));
    chk("rst_bubble",    160'(bubble_cnt), 160'(0));
    startin  = 1'b0;
    in_valid = 1'b0;

    // Streaming at full throughput.
    out_ready = 1'b1;
    push_ctrl(9'h101);
    cyc();
    chk("str_ctrl1", 160'(out_ctrl), 160'(9'h101));
    chk("str_occ1",  160'(occupancy), 160'(1));
    push_ctrl(9'h102);
    cyc();
    chk("str_ctrl2", 160'(out_ctrl), 160'(9'h102));
    chk("str_rdy2",  160'(in_ready), 160'(1));
    push_ctrl(9'h103);
    cyc();
    chk("str_ctrl3", 160'(out_ctrl), 160'(9'h103));
    chk("str_occ3",  160'(occupancy), 160'(1));
    in_valid = 1'b0;
    cyc();
    chk("str_drain", 160'(out_valid), 160'(0));

    // Backpressure fills the skid entry.
    out_ready = 1'b0;
    push_ctrl(9'h0AA);
    cyc();
    push_ctrl(9'h0BB);
    cyc();
    chk("bp_occ2",   160'(occupancy), 160'(2));
    chk("bp_rdy0",   160'(in_ready),  160'(0));
    chk("bp_hold",   160'(out_ctrl),  160'(9'h0AA));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("bp_ctrlB",  160'(out_ctrl),  160'(9'h0BB));
    chk("bp_rdy1",   160'(in_ready),  160'(1));
    cyc();
    chk("bp_empty",  160'(occupancy), 160'(0));

    // Flush while full with a simultaneous push.
    out_ready = 1'b0;
    push_ctrl(9'h0AA);
    cyc();
    push_ctrl(9'h0BB);
    cyc();
    flush = 1'b1;
    push_ctrl(9'h0CC);
    cyc();
    chk("fl_occ",    160'(occupancy), 160'(0));
    chk("fl_valid",  160'(out_valid), 160'(0));
    chk("fl_ctrl",   160'(out_ctrl),  160'(0));
    chk("fl_data",   160'(out_data),  160'(0));
    chk("fl_rdy",    160'(in_ready),  160'(1));
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc();
    chk("fl_noC",    160'(out_valid), 160'(0));

    // Bubble counter saturation, flush retention, reset clear.
    startin = 1'b1;
    cyc();
    startin   = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("bc_three", 160'(bubble_cnt), 160'(3));
    repeat (7) cyc();
    chk("bc_sat",   160'(bubble_cnt), 160'(7));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("bc_flush", 160'(bubble_cnt), 160'(7));
    startin = 1'b1;
    cyc();
    startin = 1'b0;
    chk("bc_clear", 160'(bubble_cnt), 160'(0));

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ctrl   = 9'($urandom);
      in_data   = rnd_data();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      startin   = ($urandom_range(0, 400) == 0);
      cyc();
    end
    startin  = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised, elastic successor to the fixed ID/EX pipeline register.
- Carries one control bundle and one data bundle between two pipeline stages with a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so a stall breaks no timing path.
- Also provides a synchronous flush that inserts bubbles, plus a saturating bubble counter for performance debug.
- Instantiated between ID/EX and EX/MEM in the hazard-aware pipeline.

Parameters:
- CTRL_W, 9, width of the control bundle (wb 2 + m 3 + ex 4).
- DATA_W, 148, width of the data bundle (pc+4, rs data, rt data, sign-ext imm, four 5-bit register fields).
- BUBBLE_CTRL, 0, control value presented whenever the stage holds no valid entry.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- startin  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control to next stage.
- out_data  out  DATA_W  data to next stage.
- occupancy  out  2  entries held (0..2).
- bubble_cnt  out  CNT_W  cycles where out_ready=1 and out_valid=0.

Behaviour:
- Storage is a main register (drives out_*) and a skid register. State is EMPTY(0), ONE(1) or FULL(2); occupancy encodes the state.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Transitions:
  - EMPTY + push -> ONE; main <= in.
  - ONE, push & pop -> ONE; main <= in.
  - ONE, push only -> FULL; skid <= in.
  - ONE, pop only -> EMPTY.
  - FULL + pop -> ONE; main <= skid.
  - FULL cannot push.
- in_ready = (state != FULL), derived from the state register only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). Entries leave in strict arrival order.
- Latency is 1 cycle from push to out_valid when the stage is empty. Throughput is 1 entry/cycle while out_ready=1.
- Whenever a register is vacated, its ctrl is set to BUBBLE_CTRL and its data to 0. As a result, out_ctrl=BUBBLE_CTRL and out_data=0 whenever out_valid=0.
- Flush:
  - Next state is EMPTY and both registers take bubble values.
  - Flush takes priority over a push or pop in the same cycle; an entry offered in that cycle is discarded even if in_ready=1.
  - in_ready is 1 in the cycle after a flush.
- Reset (startin=1):
  - Same effect as flush, plus bubble_cnt <= 0.
  - Reset takes priority over flush.
  - Outputs after the reset edge: in_ready=1, out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, occupancy=0, bubble_cnt=0.
  - Reset in mid-operation drops all held entries.
- bubble_cnt:
  - Increments on each cycle with out_ready=1 & out_valid=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by startin; flush does not clear it.
- Holding rules:
  - While out_ready=0, out_ctrl and out_data stay stable.
  - While FULL, the skid register holds its value.
- Upstream is expected to hold in_* stable while in_valid=1 & in_ready=0. Any change is ignored.

Decomposition:
- Shared pipeline package holds:
  - the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - default widths for the control sub-fields (WB_W=2, M_W=3, EX_W=4);
  - the bubble control constant.
- One natural sub-module, sat_counter (parametrised width, inc, clr), used for bubble_cnt.
- The EX-stage field split (reg_dst, alu_op, alu_src) is done by the consumer, not inside this block.

Test Plan:
- Reset: startin=1 for 2 cycles with in_valid=1, in_ctrl=9'h1FF -> after release out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, bubble_cnt=0.
- Streaming: out_ready=1; push ctrl 9'h101, 9'h102, 9'h103 on consecutive cycles -> out_ctrl shows 101, 102, 103 on cycles 1, 2, 3; occupancy stays at 1; in_ready stays 1.
- Backpressure: out_ready=0; push A=9'h0AA then B=9'h0BB.
  - Expected after the two pushes: occupancy=2 and in_ready=0 in the following cycle; out_ctrl holds 0AA.
  - Then raise out_ready=1 -> out_ctrl 0AA, then 0BB; in_ready=1 one cycle after the first pop.
- Flush while FULL with a simultaneous push of C=9'h0CC -> next cycle occupancy=0, out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0; C never appears on the output.
- Bubble counter: CNT_W=3; hold out_ready=1 and in_valid=0 for 10 cycles -> bubble_cnt reaches 7 and stays there. A later flush leaves it at 7; startin returns it to 0.
- Randomised push/pop against a reference queue model -> no loss, duplication or reordering; occupancy always matches the model.
